button_conditioner: RTL

Synchronises, debounces and edge-captures the five board push-buttons before they reach the PicoBlaze input mux. It replaces the raw button bits on input port 8'h0f with clean levels, and adds sticky press flags that software reads and acknowledges. It raises an interrupt-request level that the top level ORs into the processor interrupt. The block runs entirely in the pixel-clock domain, and the top level connects `pclk` to `clk`.

---
 rtl/button_conditioner.sv | 91 +++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, per-button debounce counter,
// registered press pulses and software-acknowledged sticky press flags.
module button_conditioner #(
    parameter int DB_COUNT = 400000,
    parameter int CNT_W    = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] level,
    output logic [4:0] press_pulse,
    output logic [7:0] events,
    input  logic       ack,
    input  logic [4:0] ack_mask,
    output logic       irq
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DB_COUNT - 1);

    logic [4:0] sync1_reg;
    logic [4:0] sync2_reg;
    logic [4:0] level_reg;
    logic [4:0] level_next;
    logic [4:0] rise;
    logic [4:0] press_pulse_reg;
    logic [4:0] sticky_reg;
    logic [4:0] sticky_next;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;
            logic             differs;
            logic             terminal;

            assign differs  = sync2_reg[gi] ^ level_reg[gi];
            assign terminal = (count_reg == TERMINAL);

            // Count only while the synchronised input disagrees with the
            // accepted level; any agreement restarts the window.
            always_comb begin
                count_next = '0;
                if (differs && !terminal) begin
                    count_next = count_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign level_next[gi] = (differs && terminal) ? sync2_reg[gi] : level_reg[gi];
            assign rise[gi]       = differs && terminal && sync2_reg[gi];
        end
    endgenerate

    // A press landing on the same edge as its own clear keeps the flag set.
    always_comb begin
        sticky_next = sticky_reg | rise;
        if (ack) begin
            sticky_next = (sticky_reg & ~ack_mask) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg       <= '0;
            sync2_reg       <= '0;
            level_reg       <= '0;
            press_pulse_reg <= '0;
            sticky_reg      <= '0;
        end else begin
            sync1_reg       <= btn_raw;
            sync2_reg       <= sync1_reg;
            level_reg       <= level_next;
            press_pulse_reg <= rise;
            sticky_reg      <= sticky_next;
        end
    end

    assign level       = level_reg;
    assign press_pulse = press_pulse_reg;
    assign events      = {3'b000, sticky_reg};
    assign irq         = |sticky_reg;

endmodule
